// File: rtl/pll.sv
// Counter-based stand-in for a cascaded vendor PLL pair, driven by the 50 MHz
// system clock; every generated clock and lock flag comes straight from a flop.
module pll #(
    parameter int LOCK1_CYCLES = 100,
    parameter int LOCK2_CYCLES = 50
) (
    input  logic sys_clk,
    input  logic rst_n,
    output logic clk_5MHz,
    output logic clk_10MHz,
    output logic clk_1MHz,
    output logic clk_180deg,
    output logic clk_20dc,
    output logic locked_sig1,
    output logic locked_sig2
);

    // Both lock parameters must be at least 1; zero is not a legal setting.
    localparam int W1 = $clog2(LOCK1_CYCLES + 1);
    localparam int W2 = $clog2(LOCK2_CYCLES + 1);

    logic [W1-1:0] r_cnt1;
    logic [W1-1:0] w_cnt1_nxt;
    logic [W2-1:0] r_cnt2;
    logic [W2-1:0] w_cnt2_nxt;
    logic          r_lock1;
    logic          r_lock2;
    logic          w_lock1_nxt;
    logic          w_lock2_nxt;
    logic [3:0]    r_p10;
    logic [3:0]    w_p10_nxt;
    logic [5:0]    r_p50;
    logic [5:0]    w_p50_nxt;
    logic          r_clk_5;
    logic          r_clk_10;
    logic          r_clk_1;
    logic          r_clk_180;
    logic          r_clk_20;
    logic          w_clk_5_nxt;
    logic          w_clk_10_nxt;
    logic          w_clk_1_nxt;
    logic          w_clk_180_nxt;
    logic          w_clk_20_nxt;

    // Decodes use next-state phase values so each output flop toggles on the edge itself.
    always_comb begin
        w_cnt1_nxt = r_cnt1;
        if (r_cnt1 != W1'(LOCK1_CYCLES)) begin
            w_cnt1_nxt = r_cnt1 + W1'(1);
        end
        w_lock1_nxt = (w_cnt1_nxt == W1'(LOCK1_CYCLES));

        w_cnt2_nxt = r_cnt2;
        if (r_lock1 && (r_cnt2 != W2'(LOCK2_CYCLES))) begin
            w_cnt2_nxt = r_cnt2 + W2'(1);
        end
        w_lock2_nxt = (w_cnt2_nxt == W2'(LOCK2_CYCLES));

        // Phase is 0 on the first locked cycle, then free-runs.
        w_p10_nxt = 4'd0;
        if (r_lock1) begin
            w_p10_nxt = (r_p10 == 4'd9) ? 4'd0 : r_p10 + 4'd1;
        end
        w_p50_nxt = 6'd0;
        if (r_lock2) begin
            w_p50_nxt = (r_p50 == 6'd49) ? 6'd0 : r_p50 + 6'd1;
        end

        w_clk_5_nxt   = w_lock1_nxt && (w_p10_nxt <= 4'd4);
        w_clk_180_nxt = w_lock1_nxt && (w_p10_nxt >= 4'd5);
        w_clk_20_nxt  = w_lock1_nxt && (w_p10_nxt <= 4'd1);
        w_clk_10_nxt  = w_lock1_nxt && ((w_p10_nxt == 4'd0) || (w_p10_nxt == 4'd1) ||
                                        (w_p10_nxt == 4'd5) || (w_p10_nxt == 4'd6));
        w_clk_1_nxt   = w_lock2_nxt && (w_p50_nxt <= 6'd24);
    end

    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_lock1   <= 1'b0;
            r_lock2   <= 1'b0;
            r_p10     <= 4'd0;
            r_p50     <= 6'd0;
            r_clk_5   <= 1'b0;
            r_clk_10  <= 1'b0;
            r_clk_1   <= 1'b0;
            r_clk_180 <= 1'b0;
            r_clk_20  <= 1'b0;
        end else begin
            r_cnt1    <= w_cnt1_nxt;
            r_cnt2    <= w_cnt2_nxt;
            r_lock1   <= w_lock1_nxt;
            r_lock2   <= w_lock2_nxt;
            r_p10     <= w_p10_nxt;
            r_p50     <= w_p50_nxt;
            r_clk_5   <= w_clk_5_nxt;
            r_clk_10  <= w_clk_10_nxt;
            r_clk_1   <= w_clk_1_nxt;
            r_clk_180 <= w_clk_180_nxt;
            r_clk_20  <= w_clk_20_nxt;
        end
    end

    assign clk_5MHz    = r_clk_5;
    assign clk_10MHz   = r_clk_10;
    assign clk_1MHz    = r_clk_1;
    assign clk_180deg  = r_clk_180;
    assign clk_20dc    = r_clk_20;
    assign locked_sig1 = r_lock1;
    assign locked_sig2 = r_lock2;

endmodule

// File: tb/tb_pll.sv
// Bench for pll: default instance plus a short-lock override instance, checked
// against an edge-indexed model, a hand-computed vector table and period timing.
`timescale 1ns/1ps
module tb_pll;

    logic sys_clk;
    logic rst_n;

    logic d_5, d_10, d_1, d_180, d_20, d_l1, d_l2;
    logic o_5, o_10, o_1, o_180, o_20, o_l1, o_l2;

    int n_checks = 0;
    int n_errors = 0;

    // Vector bit order: {lock2, lock1, clk_1MHz, clk_20dc, clk_180deg, clk_10MHz, clk_5MHz}
    typedef struct {
        int         k;
        logic [6:0] exp;
    } vec_t;
    vec_t vecs[$];

    time  rise_t[7];
    logic prev_v[7];

    pll u_def (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .clk_5MHz(d_5), .clk_10MHz(d_10), .clk_1MHz(d_1), .clk_180deg(d_180),
        .clk_20dc(d_20), .locked_sig1(d_l1), .locked_sig2(d_l2)
    );

    pll #(.LOCK1_CYCLES(3), .LOCK2_CYCLES(2)) u_ovr (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .clk_5MHz(o_5), .clk_10MHz(o_10), .clk_1MHz(o_1), .clk_180deg(o_180),
        .clk_20dc(o_20), .locked_sig1(o_l1), .locked_sig2(o_l2)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    function automatic logic [6:0] model(int k, int l1, int l2);
        logic [6:0] v;
        int p10, p50;
        v = 7'd0;
        if (k >= l1) begin
            p10  = (k - l1) % 10;
            v[5] = 1'b1;
            v[0] = (p10 <= 4);
            v[2] = (p10 >= 5);
            v[3] = (p10 <= 1);
            v[1] = (p10 == 0) || (p10 == 1) || (p10 == 5) || (p10 == 6);
        end
        if (k >= l1 + l2) begin
            p50  = (k - l1 - l2) % 50;
            v[6] = 1'b1;
            v[4] = (p50 <= 24);
        end
        return v;
    endfunction

    function automatic logic [6:0] def_out();
        return {d_l2, d_l1, d_1, d_20, d_180, d_10, d_5};
    endfunction

    function automatic logic [6:0] ovr_out();
        return {o_l2, o_l1, o_1, o_20, o_180, o_10, o_5};
    endfunction

    task automatic check(string name, int k, logic [6:0] act, logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s edge=%0d got=%b expected=%b", name, k, act, exp);
        end
    endtask

    task automatic reset_timing();
        for (int i = 0; i < 7; i++) begin
            rise_t[i] = 0;
            prev_v[i] = 1'b0;
        end
    endtask

    // Checks period on each rise and high time on each fall of one output bit.
    task automatic track(int idx, logic v, int period, int high);
        time now_t;
        now_t = $time;
        if (v && !prev_v[idx]) begin
            if (rise_t[idx] != 0) begin
                n_checks++;
                if (now_t - rise_t[idx] != period) begin
                    n_errors++;
                    $display("FAIL period[%0d] got=%0t expected=%0d", idx, now_t - rise_t[idx], period);
                end
            end
            rise_t[idx] = now_t;
        end else if (!v && prev_v[idx] && rise_t[idx] != 0) begin
            n_checks++;
            if (now_t - rise_t[idx] != high) begin
                n_errors++;
                $display("FAIL high_time[%0d] got=%0t expected=%0d", idx, now_t - rise_t[idx], high);
            end
        end
        prev_v[idx] = v;
    endtask

    task automatic run_phase(int n_edges, bit use_table);
        logic [6:0] a;
        reset_timing();
        for (int k = 1; k <= n_edges; k++) begin
            @(negedge sys_clk);
            a = def_out();
            check("model_def", k, a, model(k, 100, 50));
            check("model_ovr", k, ovr_out(), model(k, 3, 2));
            if (use_table) begin
                foreach (vecs[i]) begin
                    if (vecs[i].k == k) check("vector", k, a, vecs[i].exp);
                end
            end
            if (d_l1) begin
                check("inv_180", k, {6'd0, d_180}, {6'd0, ~d_5});
            end
            if (d_1 && !prev_v[4]) begin
                check("1m_on_5m_rise", k, {5'd0, d_5, prev_v[0]}, 7'b0000010);
            end
            if ((d_20 && !prev_v[3]) || (d_10 && !prev_v[1] && !prev_v[0] && d_5)) begin
                check("rise_align_5m", k, {6'd0, d_5 && !prev_v[0]}, 7'd1);
            end
            track(0, d_5, 200, 100);
            track(1, d_10, 100, 40);
            track(2, d_180, 200, 100);
            track(3, d_20, 200, 40);
            track(4, d_1, 1000, 500);
        end
    endtask

    initial begin
        vecs.push_back('{1,   7'b0000000});
        vecs.push_back('{99,  7'b0000000});
        vecs.push_back('{100, 7'b0101011});
        vecs.push_back('{101, 7'b0101011});
        vecs.push_back('{102, 7'b0100001});
        vecs.push_back('{104, 7'b0100001});
        vecs.push_back('{105, 7'b0100110});
        vecs.push_back('{106, 7'b0100110});
        vecs.push_back('{107, 7'b0100100});
        vecs.push_back('{110, 7'b0101011});
        vecs.push_back('{149, 7'b0100100});
        vecs.push_back('{150, 7'b1111011});
        vecs.push_back('{174, 7'b1110001});
        vecs.push_back('{175, 7'b1100110});
        vecs.push_back('{199, 7'b1100100});
        vecs.push_back('{200, 7'b1111011});

        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check("reset_def", -1, def_out(), 7'd0);
            check("reset_ovr", -1, ovr_out(), 7'd0);
        end
        rst_n = 1'b0;

        run_phase(400, 1'b1);

        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("midreset_def", -1, def_out(), 7'd0);
            check("midreset_ovr", -1, ovr_out(), 7'd0);
        end
        rst_n = 1'b0;

        run_phase(700, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll.md
# pll

Counter-based clock generator that stands in for a vendor PLL pair, driven by the 50 MHz system clock. Group 1 produces 5 MHz, 10 MHz, 5 MHz phase-shifted by 180° and 5 MHz at 20 % duty once `locked_sig1` asserts. Group 2 models a cascaded second PLL and produces 1 MHz once `locked_sig2` asserts. All outputs are registered in the `sys_clk` domain, and downstream logic uses the lock flags as clock-valid qualifiers.

## Interface
- `LOCK1_CYCLES`, default 100: `sys_clk` cycles from reset release to `locked_sig1` high.
- `LOCK2_CYCLES`, default 50: `sys_clk` cycles from `locked_sig1` high to `locked_sig2` high.
- `sys_clk`, input, 1: 50 MHz system clock, the only clock; all logic runs on its rising edge.
- `rst_n`, input, 1: synchronous, active-high reset. The reset is asserted when `rst_n` = 1, despite the suffix.
- `clk_5MHz`, output, 1: ÷10 of `sys_clk`, 50 % duty (5 high / 5 low).
- `clk_10MHz`, output, 1: ÷5 of `sys_clk`, 40 % duty (2 high / 3 low).
- `clk_1MHz`, output, 1: ÷50 of `sys_clk`, 50 % duty (25 high / 25 low), group 2.
- `clk_180deg`, output, 1: 5 MHz, 50 % duty, inverse phase of `clk_5MHz`.
- `clk_20dc`, output, 1: 5 MHz, 20 % duty (2 high / 8 low), rising edge aligned with `clk_5MHz`.
- `locked_sig1`, output, 1: group-1 lock flag.
- `locked_sig2`, output, 1: group-2 lock flag.

## Operation
- **Lock counter 1:** counts `sys_clk` edges while reset is deasserted and saturates at `LOCK1_CYCLES`.
  - `locked_sig1` is registered high when the count reaches `LOCK1_CYCLES`.
- **Lock counter 2:** counts only while `locked_sig1` = 1 and saturates at `LOCK2_CYCLES`.
  - `locked_sig2` is registered high when the count reaches `LOCK2_CYCLES`.
- **Phase counter `p10` (0..9, wraps 9→0):**
  - Held at 0 while `locked_sig1` = 0.
  - Is 0 on the first cycle `locked_sig1` = 1 and increments every cycle after that.
- **Phase counter `p50` (0..49, wraps 49→0):** behaves the same way relative to `locked_sig2`.
- **Group-1 decode.** Values below are per cycle, with `locked_sig1` = 1; all outputs are 0 while it is 0.
  - `clk_5MHz` = 1 when `p10` ∈ {0..4}.
  - `clk_180deg` = 1 when `p10` ∈ {5..9}.
  - `clk_20dc` = 1 when `p10` ∈ {0,1}.
  - `clk_10MHz` = 1 when `p10` ∈ {0,1,5,6}.
- **Group-2 decode:** `clk_1MHz` = 1 when `p50` ∈ {0..24} and `locked_sig2` = 1; otherwise 0.
- **Glitch-free outputs:** every output is driven directly by a flip-flop. The decodes are computed from next-state values so each output changes only on the `sys_clk` rising edge.
- **Lock behaviour once set:** both lock flags stay high until reset. There is no unlock condition.

## Timing
- **Reset (`rst_n` = 1 at a rising edge):** on the following edge, all outputs are 0 and all counters are 0.
  - This applies mid-operation too: the clocks stop low immediately and the lock flags drop.
- **Edge numbering:** edge k is the k-th rising edge with `rst_n` = 0 after reset.
- **Group-1 start:**
  - `locked_sig1` rises after edge `LOCK1_CYCLES` (100).
  - `clk_5MHz`, `clk_10MHz` and `clk_20dc` rise on that same edge.
  - `clk_180deg` rises 5 cycles later.
- **Group-2 start:**
  - `locked_sig2` rises `LOCK2_CYCLES` edges after `locked_sig1` (edge 150 by default).
  - `clk_1MHz` rises on that same edge.
- **Steady-state periods:** `clk_5MHz`, `clk_180deg` and `clk_20dc` 200 ns; `clk_10MHz` 100 ns; `clk_1MHz` 1000 ns.
- **Phase relationship:**
  - Every 10th `sys_clk` edge, the rising edges of `clk_5MHz`, `clk_20dc` and `clk_10MHz` coincide.
  - `clk_1MHz` rising edges coincide with a `clk_5MHz` rising edge. Both counters start 50 cycles apart, and 50 is a multiple of 10.
- **Reset during the lock wait:** counting restarts from 0 when reset is released.
- **Zero lock parameters:** `LOCK1_CYCLES` = 0 or `LOCK2_CYCLES` = 0 is illegal; the minimum is 1.

## Test plan
- **Reset:** hold `rst_n` = 1 for 5 cycles → all seven outputs 0 throughout.
- **Lock sequence:** release reset → `locked_sig1` rises at edge 100 and `locked_sig2` at edge 150; both stay high for 10 µs.
- **Periods and duty:** measure over 20 periods each →
  - `clk_5MHz` 200 ns, 100 ns high.
  - `clk_10MHz` 100 ns, 40 ns high.
  - `clk_1MHz` 1000 ns, 500 ns high.
  - `clk_20dc` 200 ns, 40 ns high.
- **Phase check:**
  - `clk_180deg` == ~`clk_5MHz` on every cycle after lock.
  - `clk_20dc` and `clk_10MHz` rise together with `clk_5MHz`.
  - `clk_1MHz` rises only on `clk_5MHz` rising edges.
- **Mid-operation reset:** assert `rst_n` = 1 at edge 400 for 3 cycles → outputs and lock flags 0 on the next edge. After release, `locked_sig1` re-rises 100 edges later and `locked_sig2` 150 edges later.
- **Parameter override:** `LOCK1_CYCLES` = 3, `LOCK2_CYCLES` = 2 → `locked_sig1` at edge 3 and `locked_sig2` at edge 5, with the same periods.
